// File: rtl/img_defs_pkg.sv
// Shared image definitions for the 3x3 window pipeline: frame size defaults,
// RGB332 field layout, window tap numbering and the window FSM state type.
package img_defs;

    localparam int IMG_WIDTH  = 200;
    localparam int IMG_HEIGHT = 200;

    localparam int RGB_R_W   = 3;
    localparam int RGB_G_W   = 3;
    localparam int RGB_B_W   = 2;
    localparam int RGB_PIX_W = RGB_R_W + RGB_G_W + RGB_B_W;
    localparam int RGB_B_LSB = 0;
    localparam int RGB_G_LSB = RGB_B_LSB + RGB_B_W;
    localparam int RGB_R_LSB = RGB_G_LSB + RGB_G_W;

    // Tap numbering inside the packed window {w8..w0}, row-major from top-left.
    localparam int W0 = 0;
    localparam int W1 = 1;
    localparam int W2 = 2;
    localparam int W3 = 3;
    localparam int W4 = 4;
    localparam int W5 = 5;
    localparam int W6 = 6;
    localparam int W7 = 7;
    localparam int W8 = 8;
    localparam int TAP_IDX [3][3] = '{'{W0, W1, W2}, '{W3, W4, W5}, '{W6, W7, W8}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } win_state_t;

endpackage

// File: rtl/window_3x3_gen_line_buf.sv
// line_buf: single-clock circular delay line, DEPTH entries of PIX_W bits.
// Each enabled cycle reads the entry written DEPTH enables ago and overwrites it.
module line_buf #(
    parameter int DEPTH = 200,
    parameter int PIX_W = 8
) (
    input  logic             clk_25M,
    input  logic             rst,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW-1:0]    ptr;

    assign dout = mem[ptr];

    // NOTE: the storage array has no reset so it maps onto RAM; stale contents are masked downstream.
    always_ff @(posedge clk_25M) begin
        if (en) mem[ptr] <= din;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (ptr == PTR_LAST) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: streaming 3x3 neighbourhood generator over a raster RGB332 frame.
// Define BORDER_REPLICATE_EN for edge-replicate borders; default fills out-of-image taps with zero.
module window_3x3_gen
    import img_defs::*;
#(
    parameter int WIDTH  = IMG_WIDTH,
    parameter int HEIGHT = IMG_HEIGHT,
    parameter int PIX_W  = RGB_PIX_W
) (
    input  logic               clk_25M,
    input  logic               rst,
    input  logic               sof,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [9*PIX_W-1:0] win,
    output logic               win_valid,
    output logic [7:0]         win_x,
    output logic [7:0]         win_y,
    output logic               frame_done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    win_state_t state, state_nx;
    logic       ready_q;
    logic       xfer, step, restart, emit;
    logic       primed, last_in, last_c;
    logic       edge_l, edge_r, edge_t, edge_b;
    logic       done_pend;

    logic [XW-1:0] in_x, c_x;
    logic [YW-1:0] in_y, c_y;

    // Column index 0 = top row (y-2), 1 = middle (y-1), 2 = bottom (incoming row).
    logic [PIX_W-1:0] col_new [3];
    logic [PIX_W-1:0] col_m   [3];
    logic [PIX_W-1:0] col_l   [3];
    logic [PIX_W-1:0] raw     [3][3];
    logic [PIX_W-1:0] tap     [3][3];
    logic [9*PIX_W-1:0] win_nx;

    assign pix_ready = ready_q;
    assign xfer      = pix_valid & ready_q;

    // Flush cycles push zero pixels so the line buffers keep delivering the last two rows.
    assign col_new[2] = (state == ST_FLUSH) ? '0 : pix_in;

    line_buf #(.DEPTH(WIDTH), .PIX_W(PIX_W)) u_line_y1 (
        .clk_25M (clk_25M),
        .rst     (rst),
        .en      (step),
        .din     (col_new[2]),
        .dout    (col_new[1])
    );

    line_buf #(.DEPTH(WIDTH), .PIX_W(PIX_W)) u_line_y2 (
        .clk_25M (clk_25M),
        .rst     (rst),
        .en      (step),
        .din     (col_new[1]),
        .dout    (col_new[0])
    );

    // The first WIDTH+1 pixels of a frame only fill the pipeline.
    assign primed  = (in_y != '0) && ((in_x != '0) || (in_y != YW'(1)));
    assign last_in = (in_x == X_LAST) && (in_y == Y_LAST);
    assign last_c  = (c_x == X_LAST) && (c_y == Y_LAST);

    assign edge_l = (c_x == '0);
    assign edge_r = (c_x == X_LAST);
    assign edge_t = (c_y == '0);
    assign edge_b = (c_y == Y_LAST);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx = state;
        step     = 1'b0;
        restart  = 1'b0;
        emit     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (xfer && sof) begin
                    state_nx = ST_RUN;
                    step     = 1'b1;
                    restart  = 1'b1;
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    step = 1'b1;
                    if (sof) begin
                        restart = 1'b1;
                    end else begin
                        emit = primed;
                        if (last_in) state_nx = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                step = 1'b1;
                emit = 1'b1;
                if (last_c) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Border handling keys off the centre being emitted, which also hides row wrap-around in the shift window.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            raw[r][0] = col_l[r];
            raw[r][1] = col_m[r];
            raw[r][2] = col_new[r];
        end
`ifdef BORDER_REPLICATE_EN
        for (int r = 0; r < 3; r++) begin
            tap[r][0] = edge_l ? raw[r][1] : raw[r][0];
            tap[r][1] = raw[r][1];
            tap[r][2] = edge_r ? raw[r][1] : raw[r][2];
        end
        for (int c = 0; c < 3; c++) begin
            if (edge_t) tap[0][c] = tap[1][c];
            if (edge_b) tap[2][c] = tap[1][c];
        end
`else
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if ((c == 0 && edge_l) || (c == 2 && edge_r) ||
                    (r == 0 && edge_t) || (r == 2 && edge_b))
                    tap[r][c] = '0;
                else
                    tap[r][c] = raw[r][c];
            end
        end
`endif
        win_nx = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_nx[TAP_IDX[r][c]*PIX_W +: PIX_W] = tap[r][c];
            end
        end
    end

    always_ff @(posedge clk_25M or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            ready_q    <= 1'b0;
            in_x       <= '0;
            in_y       <= '0;
            c_x        <= '0;
            c_y        <= '0;
            for (int i = 0; i < 3; i++) begin
                col_m[i] <= '0;
                col_l[i] <= '0;
            end
            win        <= '0;
            win_valid  <= 1'b0;
            win_x      <= '0;
            win_y      <= '0;
            done_pend  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            ready_q    <= (state_nx != ST_FLUSH);
            win_valid  <= emit;
            done_pend  <= emit && last_c;
            frame_done <= done_pend;

            if (step) begin
                for (int i = 0; i < 3; i++) begin
                    col_l[i] <= col_m[i];
                    col_m[i] <= col_new[i];
                end
            end

            if (emit) begin
                win   <= win_nx;
                win_x <= 8'(c_x);
                win_y <= 8'(c_y);
            end

            // The sof pixel itself is (0,0), so the next expected input is (1,0).
            if (restart) begin
                in_x <= XW'(1);
                in_y <= '0;
            end else if (step && state == ST_RUN) begin
                if (in_x == X_LAST) begin
                    in_x <= '0;
                    in_y <= (in_y == Y_LAST) ? '0 : in_y + YW'(1);
                end else begin
                    in_x <= in_x + XW'(1);
                end
            end

            if (restart) begin
                c_x <= '0;
                c_y <= '0;
            end else if (emit) begin
                if (c_x == X_LAST) begin
                    c_x <= '0;
                    c_y <= (c_y == Y_LAST) ? '0 : c_y + YW'(1);
                end else begin
                    c_x <= c_x + XW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Self-checking bench for window_3x3_gen on a 4x3 frame whose pixel values are their raster index.
// Honours BORDER_REPLICATE_EN the same way as the design.
module tb_window_3x3_gen;

    localparam int W = 4;
    localparam int H = 3;

    typedef struct {
        logic [71:0] w;
        logic [7:0]  x;
        logic [7:0]  y;
    } exp_t;

    logic        clk_25M = 1'b0;
    logic        rst;
    logic        sof;
    logic [7:0]  pix_in;
    logic        pix_valid;
    logic        pix_ready;
    logic [71:0] win;
    logic        win_valid;
    logic [7:0]  win_x;
    logic [7:0]  win_y;
    logic        frame_done;

    exp_t sb [$];
    int   checks   = 0;
    int   passed   = 0;
    int   win_seen = 0;
    int   fd_count = 0;
    bit   prev_final = 1'b0;

    window_3x3_gen #(.WIDTH(W), .HEIGHT(H), .PIX_W(8)) dut (
        .clk_25M    (clk_25M),
        .rst        (rst),
        .sof        (sof),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win        (win),
        .win_valid  (win_valid),
        .win_x      (win_x),
        .win_y      (win_y),
        .frame_done (frame_done)
    );

    always #20 clk_25M = ~clk_25M;

    function automatic logic [71:0] model_win(input int cx, input int cy, input int off);
        logic [71:0] res;
        int x, y, v;
        res = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                x = cx + c - 1;
                y = cy + r - 1;
`ifdef BORDER_REPLICATE_EN
                if (x < 0) x = 0;
                if (x > W - 1) x = W - 1;
                if (y < 0) y = 0;
                if (y > H - 1) y = H - 1;
                v = y * W + x + off;
`else
                if (x < 0 || x > W - 1 || y < 0 || y > H - 1) v = 0;
                else v = y * W + x + off;
`endif
                res[(r*3+c)*8 +: 8] = 8'(v);
            end
        end
        return res;
    endfunction

    function automatic exp_t make_exp(input int c, input int off);
        exp_t e;
        e.w = model_win(c % W, c / W, off);
        e.x = 8'(c % W);
        e.y = 8'(c / W);
        return e;
    endfunction

    // Scoreboard side: every emitted window is compared with the oldest expected entry.
    always @(negedge clk_25M) begin
        exp_t e;
        if (rst === 1'b1) begin
            if (frame_done === 1'b1) begin
                fd_count++;
                checks++;
                if (prev_final) passed++;
                else $display("FAIL frame_done_timing: frame_done without final window on previous cycle");
            end
            if (win_valid === 1'b1) begin
                win_seen++;
                checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_window: got centre (%0d,%0d) win=%h with nothing expected",
                             win_x, win_y, win);
                end else begin
                    e = sb.pop_front();
                    if (win !== e.w || win_x !== e.x || win_y !== e.y)
                        $display("FAIL window: got (%0d,%0d) %h expected (%0d,%0d) %h",
                                 win_x, win_y, win, e.x, e.y, e.w);
                    else
                        passed++;
                end
            end
            prev_final = (win_valid === 1'b1) && (win_x == 8'(W - 1)) && (win_y == 8'(H - 1));
        end else begin
            prev_final = 1'b0;
        end
    end

    // Called just after a negedge; returns at the negedge after the transfer edge.
    task automatic send(input int k, input int off, input bit s);
        pix_in    = 8'(k + off);
        sof       = s;
        pix_valid = 1'b1;
        checks++;
        if (pix_ready !== 1'b1) $display("FAIL pix_ready_send: got %b expected 1 at idx %0d", pix_ready, k);
        else passed++;
        @(posedge clk_25M);
        if (k >= W + 1) sb.push_back(make_exp(k - W - 1, off));
        if (k == W * H - 1) begin
            for (int c = k - W; c <= k; c++) sb.push_back(make_exp(c, off));
        end
        @(negedge clk_25M);
        sof = 1'b0;
    endtask

    // Flush phase: started at the negedge right after the last pixel transfer.
    task automatic expect_flush(input int w0, input int fd0, input int n_win);
        int low;
        low = 0;
        pix_valid = 1'b0;
        #1;
        while (pix_ready === 1'b0 && low < 20) begin
            low++;
            @(negedge clk_25M);
            #1;
        end
        checks++;
        if (low !== W + 1) $display("FAIL flush_ready_low: got %0d cycles expected %0d", low, W + 1);
        else passed++;
        repeat (3) @(negedge clk_25M);
        #1;
        checks++;
        if (win_seen - w0 !== n_win) $display("FAIL frame_windows: got %0d expected %0d", win_seen - w0, n_win);
        else passed++;
        checks++;
        if (fd_count - fd0 !== 1) $display("FAIL frame_done_count: got %0d expected 1", fd_count - fd0);
        else passed++;
        checks++;
        if (sb.size() !== 0) $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        else passed++;
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        sof       = 1'b0;
        pix_in    = '0;
        pix_valid = 1'b0;
        repeat (2) @(negedge clk_25M);
        checks++;
        if (pix_ready !== 1'b0) $display("FAIL reset_pix_ready: got %b expected 0", pix_ready); else passed++;
        checks++;
        if (win_valid !== 1'b0) $display("FAIL reset_win_valid: got %b expected 0", win_valid); else passed++;
        checks++;
        if (win !== '0) $display("FAIL reset_win: got %h expected 0", win); else passed++;
        checks++;
        if (win_x !== 8'd0 || win_y !== 8'd0) $display("FAIL reset_coords: got %0d,%0d expected 0,0", win_x, win_y);
        else passed++;
        checks++;
        if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b expected 0", frame_done); else passed++;
        rst = 1'b1;
        @(negedge clk_25M);
        checks++;
        if (pix_ready !== 1'b1) $display("FAIL release_pix_ready: got %b expected 1", pix_ready); else passed++;
    endtask

    task automatic test_idle_discard();
        int w0;
        w0 = win_seen;
        pix_valid = 1'b1;
        sof       = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pix_in = 8'(50 + i);
            @(negedge clk_25M);
        end
        pix_valid = 1'b0;
        repeat (2) @(negedge clk_25M);
        #1;
        checks++;
        if (win_seen !== w0) $display("FAIL idle_discard: got %0d windows expected 0", win_seen - w0); else passed++;
    endtask

    task automatic test_stream();
        int w0, fd0;
        logic [71:0] corner, centre;
`ifdef BORDER_REPLICATE_EN
        corner = {8'd5, 8'd4, 8'd4, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0};
`else
        corner = {8'd5, 8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
`endif
        centre = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        w0  = win_seen;
        fd0 = fd_count;
        for (int k = 0; k < W * H; k++) begin
            send(k, 0, k == 0);
            if (k == W) begin
                checks++;
                if (win_valid !== 1'b0) $display("FAIL early_window: got win_valid=%b expected 0 after idx %0d", win_valid, k);
                else passed++;
            end
            if (k == W + 1) begin
                checks++;
                if (win_valid !== 1'b1 || win !== corner)
                    $display("FAIL corner_00: got v=%b %h expected v=1 %h", win_valid, win, corner);
                else passed++;
            end
            if (k == 2 * W + 2) begin
                checks++;
                if (win_valid !== 1'b1 || win !== centre || win_x !== 8'd1 || win_y !== 8'd1)
                    $display("FAIL centre_11: got (%0d,%0d) %h expected (1,1) %h", win_x, win_y, win, centre);
                else passed++;
            end
        end
        #1;
        checks++;
        if (win_seen - w0 !== W * H - W - 1)
            $display("FAIL run_windows: got %0d expected %0d", win_seen - w0, W * H - W - 1);
        else passed++;
        expect_flush(w0, fd0, W * H);
    endtask

    task automatic test_bubbles();
        int w0, fd0;
        w0  = win_seen;
        fd0 = fd_count;
        for (int k = 0; k < W * H; k++) begin
            send(k, 0, k == 0);
            if (k < W * H - 1) begin
                pix_valid = 1'b0;
                @(negedge clk_25M);
                checks++;
                if (win_valid !== 1'b0) $display("FAIL bubble_window: got win_valid=%b expected 0 after idx %0d", win_valid, k);
                else passed++;
            end
        end
        expect_flush(w0, fd0, W * H);
    endtask

    task automatic test_abort();
        int w0, fd0;
        w0  = win_seen;
        fd0 = fd_count;
        for (int k = 0; k < 7; k++) send(k, 100, k == 0);
        send(0, 0, 1'b1);
        checks++;
        if (win_valid !== 1'b0) $display("FAIL abort_stale: got win_valid=%b expected 0", win_valid); else passed++;
        for (int k = 1; k < W * H; k++) send(k, 0, 1'b0);
        expect_flush(w0, fd0, W * H + 2);
    endtask

    task automatic test_reset_flush();
        int fd0;
        fd0 = fd_count;
        for (int k = 0; k < W * H; k++) send(k, 0, k == 0);
        pix_valid = 1'b0;
        repeat (2) @(negedge clk_25M);
        rst = 1'b0;
        #1;
        checks++;
        if (win_valid !== 1'b0 || win !== '0 || win_x !== 8'd0 || win_y !== 8'd0 || pix_ready !== 1'b0 || frame_done !== 1'b0)
            $display("FAIL flush_reset_outputs: got v=%b r=%b fd=%b (%0d,%0d) %h expected all 0",
                     win_valid, pix_ready, frame_done, win_x, win_y, win);
        else passed++;
        sb.delete();
        repeat (3) @(negedge clk_25M);
        rst = 1'b1;
        #1;
        checks++;
        if (pix_ready !== 1'b0) $display("FAIL release_before_edge: got pix_ready=%b expected 0", pix_ready); else passed++;
        @(negedge clk_25M);
        checks++;
        if (pix_ready !== 1'b1) $display("FAIL release_ready: got pix_ready=%b expected 1", pix_ready); else passed++;
        repeat (6) @(negedge clk_25M);
        #1;
        checks++;
        if (fd_count !== fd0) $display("FAIL reset_no_frame_done: got %0d pulses expected 0", fd_count - fd0); else passed++;
    endtask

    task automatic test_back_to_back();
        int w0, fd0;
        @(negedge clk_25M);
        w0  = win_seen;
        fd0 = fd_count;
        for (int k = 0; k < W * H; k++) send(k, 0, k == 0);
        expect_flush(w0, fd0, W * H);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle_discard();
        test_stream();
        test_bubbles();
        test_abort();
        test_reset_flush();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
